tdc_acq_controller: RTL

TDC_ACQ_CONTROLLER -- requirements
Module: tdc_acq_controller

---
 rtl/tdc_acq_controller.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/tdc_acq_controller.sv
// TDC acquisition-window controller: runs one gated counting window per request and holds the result until it is taken.
// Optional macro ACCIDENTAL_CORR_EN adds an offset-gate accidental-coincidence counter (acc_cnt, ACC_OFFSET).
module tdc_acq_controller #(
   parameter int CNT_W = 16,
   parameter int WIN_W = 24
`ifdef ACCIDENTAL_CORR_EN
   ,
   parameter int ACC_OFFSET = 32
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             acq_start,
   input  logic             acq_abort,
   input  logic [WIN_W-1:0] acq_len,
   input  logic [6:0]       gate_lo,
   input  logic [6:0]       gate_hi,
   input  logic             data_arrived,
   input  logic [6:0]       interval,
   output logic             tdc_en,
   output logic             busy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [CNT_W-1:0] event_cnt,
   output logic [CNT_W-1:0] coinc_cnt,
`ifdef ACCIDENTAL_CORR_EN
   output logic [CNT_W-1:0] acc_cnt,
`endif
   output logic             overflow,
   output logic             aborted
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      DRAIN   = 2'd2,
      REPORT  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIN_W-1:0] win_q, win_d;
   logic [6:0]       gate_lo_q, gate_lo_d;
   logic [6:0]       gate_hi_q, gate_hi_d;
   logic [CNT_W-1:0] event_q, event_d;
   logic [CNT_W-1:0] coinc_q, coinc_d;
   logic             overflow_q, overflow_d;
   logic             aborted_q, aborted_d;
   logic             tdc_en_q, tdc_en_d;
   logic             busy_q, busy_d;
   logic             res_valid_q, res_valid_d;
   logic             counting;
   logic             in_gate;
`ifdef ACCIDENTAL_CORR_EN
   logic [CNT_W-1:0] acc_q, acc_d;
   logic [7:0]       acc_lo, acc_hi, interval_w;
   logic             in_acc;
`endif

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic sat_hit(input logic [CNT_W-1:0] v);
      return &v;
   endfunction

   assign counting = data_arrived && (state_q == ACQUIRE || state_q == DRAIN);
   assign in_gate  = (interval >= gate_lo_q) && (interval <= gate_hi_q);

`ifdef ACCIDENTAL_CORR_EN
   // 8-bit compare so an offset gate past 127 does not wrap back into range
   assign acc_lo     = {1'b0, gate_lo_q} + 8'(ACC_OFFSET);
   assign acc_hi     = {1'b0, gate_hi_q} + 8'(ACC_OFFSET);
   assign interval_w = {1'b0, interval};
   assign in_acc     = (interval_w >= acc_lo) && (interval_w <= acc_hi);
`endif

   always_comb begin
      state_d    = state_q;
      win_d      = win_q;
      gate_lo_d  = gate_lo_q;
      gate_hi_d  = gate_hi_q;
      event_d    = event_q;
      coinc_d    = coinc_q;
      overflow_d = overflow_q;
      aborted_d  = aborted_q;
`ifdef ACCIDENTAL_CORR_EN
      acc_d      = acc_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (acq_start) begin
               gate_lo_d  = gate_lo;
               gate_hi_d  = gate_hi;
               win_d      = acq_len;
               event_d    = '0;
               coinc_d    = '0;
               overflow_d = 1'b0;
               aborted_d  = 1'b0;
`ifdef ACCIDENTAL_CORR_EN
               acc_d      = '0;
`endif
               state_d    = (acq_len == '0) ? REPORT : ACQUIRE;
            end
         end
         ACQUIRE: begin
            // win_q holds the ACQUIRE cycles still to run, including this one
            if (acq_abort || win_q == WIN_W'(1)) begin
               aborted_d = aborted_q | acq_abort;
               win_d     = WIN_W'(1);
               state_d   = DRAIN;
            end else begin
               win_d = win_q - WIN_W'(1);
            end
         end
         DRAIN: begin
            if (acq_abort || win_q == '0) begin
               aborted_d = aborted_q | acq_abort;
               state_d   = REPORT;
            end else begin
               win_d = win_q - WIN_W'(1);
            end
         end
         REPORT: begin
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (counting) begin
         event_d    = sat_inc(event_q);
         overflow_d = overflow_d | sat_hit(event_q);
         if (in_gate) begin
            coinc_d    = sat_inc(coinc_q);
            overflow_d = overflow_d | sat_hit(coinc_q);
         end
`ifdef ACCIDENTAL_CORR_EN
         if (in_acc) begin
            acc_d      = sat_inc(acc_q);
            overflow_d = overflow_d | sat_hit(acc_q);
         end
`endif
      end

      tdc_en_d    = (state_d == ACQUIRE);
      busy_d      = (state_d != IDLE);
      res_valid_d = (state_d == REPORT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         win_q       <= '0;
         event_q     <= '0;
         coinc_q     <= '0;
         overflow_q  <= 1'b0;
         aborted_q   <= 1'b0;
         tdc_en_q    <= 1'b0;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
`ifdef ACCIDENTAL_CORR_EN
         acc_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         win_q       <= win_d;
         event_q     <= event_d;
         coinc_q     <= coinc_d;
         overflow_q  <= overflow_d;
         aborted_q   <= aborted_d;
         tdc_en_q    <= tdc_en_d;
         busy_q      <= busy_d;
         res_valid_q <= res_valid_d;
`ifdef ACCIDENTAL_CORR_EN
         acc_q       <= acc_d;
`endif
      end
      gate_lo_q <= gate_lo_d;
      gate_hi_q <= gate_hi_d;
   end

   assign tdc_en    = tdc_en_q;
   assign busy      = busy_q;
   assign res_valid = res_valid_q;
   assign event_cnt = event_q;
   assign coinc_cnt = coinc_q;
   assign overflow  = overflow_q;
   assign aborted   = aborted_q;
`ifdef ACCIDENTAL_CORR_EN
   assign acc_cnt   = acc_q;
`endif

endmodule
